// File: rtl/vdp99_cpu_port.sv
// vdp99_cpu_port: Z80-side control/data port responder for the vdp99.
// Two-byte control sequence, status read, VRAM access with read-ahead.
module vdp99_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              phi,
  input  logic              reset,
  input  logic              cpu_mode,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              reg_we,
  output logic [2:0]        reg_num,
  output logic [7:0]        reg_val,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  input  logic [7:0]        status_in,
  output logic              status_clr,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE,
    WREQ,
    RREQ
  } state_t;

  state_t            state;
  logic              wr_q;
  logic              rd_q;
  logic              rd_act;
  logic              rd_ctl;
  logic              second;
  logic [7:0]        latch;
  logic [7:0]        rbuf;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] setup_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] setup_inc;
  logic              wr_start;
  logic              rd_start;
  logic              rd_fin;
  logic              busy;

  // A read colliding with a write start is ignored; rd_act
  // remembers whether the current read was accepted.
  assign wr_start   = cpu_wr & ~wr_q;
  assign rd_start   = cpu_rd & ~rd_q & ~wr_start;
  assign rd_fin     = ~cpu_rd & rd_q & rd_act;
  assign busy       = (state != IDLE);
  assign setup_addr = ADDR_W'({cpu_din[5:0], latch});
  assign addr_inc   = addr + ADDR_W'(1);
  assign setup_inc  = setup_addr + ADDR_W'(1);

  // Strobe decode, control sequencing and the VRAM request FSM.
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_act     <= 1'b0;
      rd_ctl     <= 1'b0;
      second     <= 1'b0;
      latch      <= 8'h00;
      rbuf       <= 8'h00;
      addr       <= '0;
      cpu_dout   <= 8'h00;
      reg_we     <= 1'b0;
      reg_num    <= 3'd0;
      reg_val    <= 8'h00;
      vram_req   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      status_clr <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_q       <= cpu_wr;
      rd_q       <= cpu_rd;
      reg_we     <= 1'b0;
      status_clr <= 1'b0;

      if (busy && vram_ack) begin
        state    <= IDLE;
        vram_req <= 1'b0;
        if (state == RREQ) begin
          rbuf <= vram_rdata;
        end
      end

      if (rd_start) begin
        rd_ctl <= cpu_mode;
        if (cpu_mode) begin
          rd_act   <= 1'b1;
          cpu_dout <= status_in;
        end else if (!busy) begin
          rd_act   <= 1'b1;
          cpu_dout <= rbuf;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (rd_fin) begin
        rd_act <= 1'b0;
        second <= 1'b0;
        if (rd_ctl) begin
          status_clr <= 1'b1;
        end else if (busy) begin
          overrun <= 1'b1;
        end else begin
          state     <= RREQ;
          vram_req  <= 1'b1;
          vram_we   <= 1'b0;
          vram_addr <= addr;
          addr      <= addr_inc;
        end
      end

      if (wr_start) begin
        if (cpu_mode) begin
          if (!second) begin
            latch  <= cpu_din;
            second <= 1'b1;
          end else begin
            second <= 1'b0;
            if (cpu_din[7]) begin
              reg_we  <= 1'b1;
              reg_num <= cpu_din[2:0];
              reg_val <= latch;
            end else if (cpu_din[6]) begin
              addr <= setup_addr;
            end else if (busy) begin
              overrun <= 1'b1;
            end else begin
              state     <= RREQ;
              vram_req  <= 1'b1;
              vram_we   <= 1'b0;
              vram_addr <= setup_addr;
              addr      <= setup_inc;
            end
          end
        end else begin
          second <= 1'b0;
          if (busy) begin
            overrun <= 1'b1;
          end else begin
            state      <= WREQ;
            vram_req   <= 1'b1;
            vram_we    <= 1'b1;
            vram_addr  <= addr;
            vram_wdata <= cpu_din;
            rbuf       <= cpu_din;
            addr       <= addr_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vdp99_cpu_port.sv
// tb_vdp99_cpu_port: directed and randomized checks of vdp99_cpu_port
// against a byte-level model of the two-port VDP protocol.
module tb_vdp99_cpu_port;

  logic        phi = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_mode = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  cpu_dout;
  logic        reg_we;
  logic [2:0]  reg_num;
  logic [7:0]  reg_val;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack;
  logic [7:0]  vram_rdata;
  logic        status_clr;
  logic        overrun;

  logic        resp_ack = 1'b0;
  logic [7:0]  resp_rdata = 8'h00;
  logic        inj_ack = 1'b0;
  logic        hold = 1'b0;

  assign vram_ack   = resp_ack | inj_ack;
  assign vram_rdata = inj_ack ? 8'hE7 : resp_rdata;

  vdp99_cpu_port #(.ADDR_W(14)) dut (
    .phi        (phi),
    .reset      (reset),
    .cpu_mode   (cpu_mode),
    .cpu_din    (cpu_din),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_dout   (cpu_dout),
    .reg_we     (reg_we),
    .reg_num    (reg_num),
    .reg_val    (reg_val),
    .vram_req   (vram_req),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_ack   (vram_ack),
    .vram_rdata (vram_rdata),
    .status_in  (status_in),
    .status_clr (status_clr),
    .overrun    (overrun)
  );

  always #5 phi = ~phi;

  int cyc = 0;
  always @(posedge phi) cyc <= cyc + 1;

  // pulse monitors, sampled mid-cycle
  int         rwe_cnt = 0;
  int         rwe_cyc = 0;
  int         sc_cnt = 0;
  int         sc_cyc = 0;
  int         req_cyc = 0;
  logic       req_prev = 1'b0;
  logic [2:0] last_num = 3'd0;
  logic [7:0] last_val = 8'h00;

  always @(negedge phi) begin
    if (reg_we === 1'b1) begin
      rwe_cnt  <= rwe_cnt + 1;
      rwe_cyc  <= cyc;
      last_num <= reg_num;
      last_val <= reg_val;
    end
    if (status_clr === 1'b1) begin
      sc_cnt <= sc_cnt + 1;
      sc_cyc <= cyc;
    end
    if (vram_req === 1'b1 && !req_prev) req_cyc <= cyc;
    req_prev <= vram_req;
  end

  // VRAM responder with random ack latency; logs every serviced request
  bit   [7:0]  vram [16384];
  int          wcnt = 0;
  logic [22:0] log_q[$];
  logic [22:0] last_req = '0;

  always @(negedge phi) begin
    if (resp_ack) begin
      resp_ack <= 1'b0;
    end else if (vram_req === 1'b1 && !hold) begin
      if (wcnt == 0) begin
        resp_ack <= 1'b1;
        wcnt     <= $urandom_range(0, 3);
        if (vram_we) begin
          vram[vram_addr] <= vram_wdata;
          log_q.push_back({1'b1, vram_addr, vram_wdata});
          last_req <= {1'b1, vram_addr, vram_wdata};
        end else begin
          resp_rdata <= vram[vram_addr];
          log_q.push_back({1'b0, vram_addr, vram[vram_addr]});
          last_req <= {1'b0, vram_addr, vram[vram_addr]};
        end
      end else begin
        wcnt <= wcnt - 1;
      end
    end
  end

  // reference model: pointer, latch, sequence flag, read buffer, memory
  int          m_addr = 0;
  logic [7:0]  m_latch = 8'h00;
  logic [7:0]  m_rbuf = 8'h00;
  bit          m_second = 1'b0;
  bit   [7:0]  m_mem [16384];
  logic [22:0] exp_q[$];
  int          exp_rwe = 0;
  int          exp_sc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t_start = 0;
  int          t_rel = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_wait();
    int k = 0;
    @(negedge phi);
    while (vram_req === 1'b1 && k < 40) begin
      @(negedge phi);
      k++;
    end
    chk("req_timeout", {31'b0, vram_req}, 32'd0);
    repeat (2) @(negedge phi);
  endtask

  task automatic check_model();
    chk("req_count", log_q.size(), exp_q.size());
    while (log_q.size() > 0 && exp_q.size() > 0)
      chk("req_entry", log_q.pop_front(), exp_q.pop_front());
    log_q.delete();
    exp_q.delete();
    chk("reg_we_count", rwe_cnt, exp_rwe);
    chk("status_clr_count", sc_cnt, exp_sc);
  endtask

  function automatic void m_read_req();
    exp_q.push_back({1'b0, 14'(m_addr), m_mem[m_addr]});
    m_rbuf = m_mem[m_addr];
    m_addr = (m_addr + 1) % 16384;
  endfunction

  task automatic ctl_wr(input logic [7:0] b);
    bit         isreg = 0;
    bit         isrd = 0;
    logic [2:0] xn = 3'd0;
    logic [7:0] xv = 8'h00;
    if (!m_second) begin
      m_latch  = b;
      m_second = 1'b1;
    end else begin
      m_second = 1'b0;
      if (b[7]) begin
        isreg = 1;
        exp_rwe++;
        xn = b[2:0];
        xv = m_latch;
      end else begin
        m_addr = int'(b[5:0]) * 256 + int'(m_latch);
        if (!b[6]) begin
          isrd = 1;
          m_read_req();
        end
      end
    end
    @(negedge phi);
    cpu_mode = 1'b1;
    cpu_din  = b;
    cpu_wr   = 1'b1;
    t_start  = cyc;
    repeat (2) @(negedge phi);
    cpu_wr = 1'b0;
    idle_wait();
    if (isreg) begin
      chk("reg_num", last_num, xn);
      chk("reg_val", last_val, xv);
      chk("reg_we_latency", rwe_cyc, t_start + 1);
    end
    if (isrd) chk("readahead_latency", req_cyc, t_start + 1);
    check_model();
  endtask

  task automatic dat_wr(input logic [7:0] b);
    exp_q.push_back({1'b1, 14'(m_addr), b});
    m_mem[m_addr] = b;
    m_rbuf   = b;
    m_addr   = (m_addr + 1) % 16384;
    m_second = 1'b0;
    @(negedge phi);
    cpu_mode = 1'b0;
    cpu_din  = b;
    cpu_wr   = 1'b1;
    t_start  = cyc;
    repeat (2) @(negedge phi);
    cpu_wr = 1'b0;
    idle_wait();
    chk("wr_req_latency", req_cyc, t_start + 1);
    check_model();
  endtask

  task automatic dat_rd(output logic [7:0] got);
    logic [7:0] exp = m_rbuf;
    @(negedge phi);
    cpu_mode = 1'b0;
    cpu_rd   = 1'b1;
    @(negedge phi);
    got = cpu_dout;
    chk("rd_data", got, exp);
    repeat (2) @(negedge phi);
    chk("rd_hold", cpu_dout, exp);
    cpu_rd = 1'b0;
    t_rel  = cyc;
    m_read_req();
    m_second = 1'b0;
    idle_wait();
    chk("prefetch_latency", req_cyc, t_rel + 1);
    check_model();
  endtask

  task automatic ctl_rd(input logic [7:0] st, output logic [7:0] got);
    @(negedge phi);
    status_in = st;
    cpu_mode  = 1'b1;
    cpu_rd    = 1'b1;
    @(negedge phi);
    got = cpu_dout;
    chk("status_data", got, st);
    status_in = ~st;
    repeat (2) @(negedge phi);
    chk("status_hold", cpu_dout, st);
    cpu_rd = 1'b0;
    t_rel  = cyc;
    exp_sc++;
    m_second = 1'b0;
    idle_wait();
    chk("status_clr_latency", sc_cyc, t_rel + 1);
    check_model();
  endtask

  task automatic raw_dat_wr(input logic [7:0] b);
    @(negedge phi);
    cpu_mode = 1'b0;
    cpu_din  = b;
    cpu_wr   = 1'b1;
    repeat (2) @(negedge phi);
    cpu_wr = 1'b0;
    @(negedge phi);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] r;
    int         op;

    repeat (3) @(negedge phi);
    chk("rst_cpu_dout", cpu_dout, 8'h00);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_vram_req", vram_req, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;

    // register write
    ctl_wr(8'h70);
    ctl_wr(8'h81);
    chk("t1_num", last_num, 3'd1);
    chk("t1_val", last_val, 8'h70);

    // write address setup and data writes
    ctl_wr(8'h00);
    ctl_wr(8'h48);
    dat_wr(8'h41);
    chk("t2_req0", last_req, {1'b1, 14'h0800, 8'h41});
    dat_wr(8'h42);
    chk("t2_req1", last_req, {1'b1, 14'h0801, 8'h42});
    ctl_wr(8'h00);
    ctl_wr(8'h48);
    dat_wr(8'h5A);

    // read address setup with read-ahead
    ctl_wr(8'h00);
    ctl_wr(8'h08);
    chk("t3_ra", last_req, {1'b0, 14'h0800, 8'h5A});
    dat_rd(got);
    chk("t3_data", got, 8'h5A);
    chk("t3_pf", last_req, {1'b0, 14'h0801, 8'h42});

    // status read resets the byte sequence
    ctl_wr(8'h12);
    ctl_rd(8'h80, got);
    chk("t4_status", got, 8'h80);
    chk("t4_clr", sc_cnt, 1);
    ctl_wr(8'h34);
    chk("t4_no_reg", rwe_cnt, 1);
    ctl_rd(8'h05, got);

    // address wrap
    ctl_wr(8'hFF);
    ctl_wr(8'h7F);
    dat_wr(8'hAA);
    chk("t5_top", last_req, {1'b1, 14'h3FFF, 8'hAA});
    dat_wr(8'hBB);
    chk("t5_wrap", last_req, {1'b1, 14'h0000, 8'hBB});

    // overrun while ack withheld
    hold = 1'b1;
    raw_dat_wr(8'hCC);
    chk("t5_pend_req", vram_req, 1);
    chk("t5_pend_addr", vram_addr, 14'h0001);
    chk("t5_no_ovr", overrun, 0);
    raw_dat_wr(8'hDD);
    chk("t5_overrun", overrun, 1);
    chk("t5_keep_data", vram_wdata, 8'hCC);

    // asynchronous reset mid-request
    @(negedge phi);
    #2 reset = 1'b0;
    #1;
    chk("t6_cpu_dout", cpu_dout, 8'h00);
    chk("t6_reg_we", reg_we, 0);
    chk("t6_reg_num", reg_num, 0);
    chk("t6_reg_val", reg_val, 8'h00);
    chk("t6_vram_req", vram_req, 0);
    chk("t6_vram_we", vram_we, 0);
    chk("t6_vram_addr", vram_addr, 0);
    chk("t6_vram_wdata", vram_wdata, 8'h00);
    chk("t6_status_clr", status_clr, 0);
    chk("t6_overrun", overrun, 0);
    @(negedge phi);
    reset   = 1'b1;
    hold    = 1'b0;
    inj_ack = 1'b1;
    @(negedge phi);
    inj_ack  = 1'b0;
    m_addr   = 0;
    m_latch  = 8'h00;
    m_rbuf   = 8'h00;
    m_second = 1'b0;
    log_q.delete();
    exp_q.delete();
    repeat (2) @(negedge phi);
    dat_rd(got);
    chk("t6_rbuf", got, 8'h00);

    // randomized traffic over a small address window
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 5);
      r  = 8'($urandom);
      case (op)
        0: begin
          ctl_wr(r);
          ctl_wr(8'h80 | (r & 8'h07));
        end
        1: begin
          ctl_wr(8'($urandom_range(0, 15)));
          ctl_wr(8'($urandom_range(0, 1)));
        end
        2: begin
          ctl_wr(8'($urandom_range(0, 15)));
          ctl_wr(8'h40 | 8'($urandom_range(0, 1)));
        end
        3: dat_wr(r);
        4: dat_rd(got);
        default: ctl_rd(r, got);
      endcase
    end
    chk("final_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vdp99_cpu_port.md
# vdp99_cpu_port

CPU-side responder for the nouveau-vdp99 video processor. It decodes Z80 I/O cycles presented as `cpu_wr`/`cpu_rd` strobes plus a port-select bit. It implements the TMS9918-style two-port protocol: a control port for the two-byte register-write and address-setup sequence plus status read, and a data port for VRAM read/write with read-ahead and address auto-increment. It sits between the Z80 bus glue and the VDP core: it issues register writes to the register file and single-byte requests to the VRAM arbiter.

## Interface
- `ADDR_W`, default 14: VRAM address width, 16 KiB.
- `phi` in 1: CPU clock; every input is synchronous to it.
- `reset` in 1: asynchronous, active-low.
- `cpu_mode` in 1: port select. 0 = data port, 1 = control port.
- `cpu_din` in 8: write data, valid while `cpu_wr` is high.
- `cpu_wr` in 1: write strobe, level, held at least 2 `phi` cycles.
- `cpu_rd` in 1: read strobe, level, held at least 3 `phi` cycles.
- `cpu_dout` out 8: read data, registered.
- `reg_we` out 1: one-cycle register-write pulse.
- `reg_num` out 3: register index.
- `reg_val` out 8: register value.
- `vram_req` out 1: VRAM request, held until acknowledged.
- `vram_we` out 1: 1 = write, 0 = read. Valid while `vram_req` is high.
- `vram_addr` out ADDR_W: request address.
- `vram_wdata` out 8: write data.
- `vram_ack` in 1: one-cycle acknowledge. For a read, `vram_rdata` is valid in the same cycle.
- `vram_rdata` in 8: read data.
- `status_in` in 8: live VDP status byte.
- `status_clr` out 1: one-cycle pulse; tells the core to clear the frame/IRQ status flags.
- `overrun` out 1: sticky flag; a data-port access arrived while a VRAM request was outstanding.

## Operation
- Edge detection: registered copies `wr_q`/`rd_q`. An access starts on the first edge where the strobe is high and its `_q` is low. A read finishes on the first edge where `cpu_rd` is low and `rd_q` is high. Each strobe acts exactly once.
- State: `addr` (ADDR_W), `latch` (8), `second` flag, `rbuf` (8). The request FSM has states IDLE, WREQ, RREQ.
- Control write, `second`=0: `latch`←`cpu_din`, `second`←1.
- Control write, `second`=1, `cpu_din[7]`=1: register write. Pulse `reg_we`, `reg_num`=`cpu_din[2:0]`, `reg_val`=`latch`. `second`←0.
- Control write, `second`=1, `cpu_din[7]`=0: address setup. `addr`←{`cpu_din[5:0]`,`latch`}, `second`←0. If `cpu_din[6]`=0, also issue a read-ahead: go to RREQ at `addr`.
- Data write: `vram_wdata`=`cpu_din`, `rbuf`←`cpu_din`, go to WREQ at `addr`, `addr`←`addr`+1. `second`←0.
- Data read, start: `cpu_dout`←`rbuf`. At finish: go to RREQ at `addr` (prefetch), `addr`←`addr`+1 on issue. `second`←0.
- Control read, start: `cpu_dout`←`status_in`, sampled once. At finish: pulse `status_clr`, `second`←0.
- Address increment wraps modulo 2^ADDR_W: 0x3FFF → 0x0000.
- Address-setup read-ahead also increments `addr` when issued.
- WREQ/RREQ: `vram_req`=1 with stable `vram_we`/`vram_addr`/`vram_wdata`. On `vram_ack` return to IDLE. In RREQ, `rbuf`←`vram_rdata` on ack.
- Busy handling: a data access or a read-ahead-producing address setup arriving in WREQ/RREQ is dropped and sets `overrun`. Register writes, status reads and first-byte latching still proceed.
- Simultaneous `cpu_wr` and `cpu_rd` starts: the write wins and the read is ignored.
- `reset` low: all state clears immediately, mid-request included. `vram_req` drops and any later ack is ignored.

## Timing
- Reset values: `cpu_dout`=0x00, `reg_we`=0, `reg_num`=0, `reg_val`=0x00, `vram_req`=0, `vram_we`=0, `vram_addr`=0, `vram_wdata`=0x00, `status_clr`=0, `overrun`=0. Internal `addr`=0, `second`=0, `rbuf`=0x00.
- Let E be the edge that detects a start. `reg_we`, `vram_req` (writes and setup read-ahead) and `cpu_dout` become valid after E, i.e. 1-cycle latency.
- `cpu_dout` stays stable until the next read start.
- `reg_we` and `status_clr` are high for exactly one cycle.
- A read prefetch raises `vram_req` after the finish edge F.
- `vram_ack` may arrive in the first request cycle at the earliest. Arbitrary wait is allowed. `vram_req` falls after the ack edge.
- `rbuf` is updated at the ack edge, so it is valid for a data read starting on the next edge.

## Test plan
- Write 0x70 then 0x81 to the control port → single `reg_we` pulse, `reg_num`=1, `reg_val`=0x70. No `vram_req`.
- Control 0x00, 0x48, then data 0x41 → write request with `vram_we`=1, `vram_addr`=0x0800, `vram_wdata`=0x41. A following data write goes to 0x0801.
- Control 0x00, 0x08 → read request at 0x0800; ack with `vram_rdata`=0x5A. A data read then returns `cpu_dout`=0x5A, followed by a prefetch request at 0x0801.
- With `status_in`=0x80, write control 0x12 then read control → `cpu_dout`=0x80 and a `status_clr` pulse after `cpu_rd` falls. A further control write of 0x34 is treated as a first byte, so no `reg_we`.
- Address setup to 0x3FFF, then a data write → request at 0x3FFF; the next write goes to 0x0000. A data write issued while the ack is withheld sets `overrun`=1.
- Assert `reset` low while `vram_req`=1 → all outputs return to reset values immediately; a late `vram_ack` leaves `rbuf` at 0x00.
